// File: rtl/dpram_pkg.sv
// Shared types and helpers for the wide byte-enabled dual-port RAM.
// Holds the clear-engine state enum, address wrap arithmetic and parameter checks.
package dpram_pkg;

  typedef enum logic {
    IDLE  = 1'b0,
    CLEAR = 1'b1
  } clr_state_e;

  function automatic int unsigned port_w(input int unsigned lanes, input int unsigned data_width);
    return lanes * data_width;
  endfunction

  function automatic int unsigned clr_words(input int unsigned line, input int unsigned lanes);
    return (line + lanes - 1) / lanes;
  endfunction

  // Byte k of an access starting at addr; addr may exceed line and is reduced first.
  function automatic int unsigned wrap_idx(input int unsigned addr, input int unsigned k,
                                           input int unsigned line);
    int unsigned s;
    s = (addr % line) + k;
    return (s >= line) ? s - line : s;
  endfunction

  function automatic bit rd_lat_ok(input int unsigned lat);
    return (lat == 1) || (lat == 2);
  endfunction

endpackage

// File: rtl/dpram_clear_fsm.sv
// Memory-clear engine: sweeps zero writes of LANES bytes per cycle over the whole array.
//   state | meaning
//   IDLE  | memory usable, ports accepted
//   CLEAR | zero-writing word at clr_ptr, ports ignored
module dpram_clear_fsm
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned ADDR_LINE  = 519168,
  parameter int unsigned LANES      = 16
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  clr,
  output logic                  init_busy,
  output logic                  clr_we,
  output logic [ADDR_WIDTH:0]   clr_ptr
);

  localparam int unsigned CLR_WORDS = clr_words(ADDR_LINE, LANES);
  localparam int unsigned CW = ($clog2(CLR_WORDS) > 0) ? $clog2(CLR_WORDS) : 1;
  localparam int unsigned PW = ADDR_WIDTH + 1;

  clr_state_e     state_q, state_d;
  logic [PW-1:0]  ptr_q, ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= CLEAR;
      ptr_q   <= '0;
      cnt_q   <= CW'(CLR_WORDS - 1);
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  // cnt_q counts remaining words down to the terminal word
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        if (clr) begin
          state_d = CLEAR;
          ptr_d   = '0;
          cnt_d   = CW'(CLR_WORDS - 1);
        end
      end
      CLEAR: begin
        if (clr) begin
          ptr_d = '0;
          cnt_d = CW'(CLR_WORDS - 1);
        end else if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          ptr_d = ptr_q + PW'(LANES);
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign init_busy = (state_q == CLEAR);
  assign clr_we    = (state_q == CLEAR);
  assign clr_ptr   = ptr_q;

endmodule

// File: rtl/dpram_wide_be.sv
// Wide dual-port byte RAM with byte enables, wrapped addressing, pipelined reads and clear engine.
// Optional cross-port write-collision flag built when DPRAM_COLL_DET_EN is defined.
module dpram_wide_be
  import dpram_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 19,
  parameter int unsigned ADDR_LINE  = 519168,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LANES      = 16,
  parameter int unsigned RD_LAT     = 1
) (
  input  logic                          clk,
  input  logic                          rst_n,
  input  logic                          clr,
  output logic                          init_busy,
  input  logic                          en_a,
  input  logic                          we_a,
  input  logic [LANES-1:0]              be_a,
  input  logic [ADDR_WIDTH-1:0]         addr_a,
  input  logic [LANES*DATA_WIDTH-1:0]   din_a,
  output logic [LANES*DATA_WIDTH-1:0]   dout_a,
  output logic                          rvalid_a,
  input  logic                          en_b,
  input  logic                          we_b,
  input  logic [LANES-1:0]              be_b,
  input  logic [ADDR_WIDTH-1:0]         addr_b,
  input  logic [LANES*DATA_WIDTH-1:0]   din_b,
  output logic [LANES*DATA_WIDTH-1:0]   dout_b,
  output logic                          rvalid_b,
  output logic                          coll
);

  localparam int unsigned W  = port_w(LANES, DATA_WIDTH);
  localparam int unsigned IW = (ADDR_LINE > 1) ? $clog2(ADDR_LINE) : 1;

  if (!rd_lat_ok(RD_LAT)) begin : g_bad_rd_lat
    $error("dpram_wide_be: RD_LAT must be 1 or 2");
  end

  logic [DATA_WIDTH-1:0] mem [ADDR_LINE];

  logic                  clr_we;
  logic [ADDR_WIDTH:0]   clr_ptr;

  dpram_clear_fsm #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .ADDR_LINE  (ADDR_LINE),
    .LANES      (LANES)
  ) u_clear (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .init_busy (init_busy),
    .clr_we    (clr_we),
    .clr_ptr   (clr_ptr)
  );

  logic                  en     [2];
  logic                  we     [2];
  logic [LANES-1:0]      be     [2];
  logic [ADDR_WIDTH-1:0] addr   [2];
  logic [W-1:0]          din    [2];
  logic                  acc_wr [2];
  logic                  acc_rd [2];
  logic [IW-1:0]         idx    [2][LANES];

  assign en[0]   = en_a;   assign en[1]   = en_b;
  assign we[0]   = we_a;   assign we[1]   = we_b;
  assign be[0]   = be_a;   assign be[1]   = be_b;
  assign addr[0] = addr_a; assign addr[1] = addr_b;
  assign din[0]  = din_a;  assign din[1]  = din_b;

  always_comb begin
    for (int p = 0; p < 2; p++) begin
      acc_wr[p] = en[p] & we[p] & ~init_busy;
      acc_rd[p] = en[p] & ~we[p] & ~init_busy;
      for (int k = 0; k < LANES; k++) begin
        idx[p][k] = IW'(wrap_idx(32'(addr[p]), k, ADDR_LINE));
      end
    end
  end

  // Port B is applied before port A so A's byte wins on a shared address.
  always_ff @(posedge clk) begin
    if (clr_we) begin
      for (int k = 0; k < LANES; k++) begin
        if (32'(clr_ptr) + k < ADDR_LINE) mem[IW'(32'(clr_ptr) + k)] <= '0;
      end
    end
    for (int p = 1; p >= 0; p--) begin
      if (acc_wr[p]) begin
        for (int k = 0; k < LANES; k++) begin
          if (be[p][k]) mem[idx[p][k]] <= din[p][k*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  for (genvar p = 0; p < 2; p++) begin : g_port
    logic [W-1:0] rdata;
    logic [W-1:0] dout_q;
    logic         rvalid_q;

    always_comb begin
      rdata = '0;
      for (int k = 0; k < LANES; k++) rdata[k*DATA_WIDTH +: DATA_WIDTH] = mem[idx[p][k]];
    end

    if (RD_LAT == 2) begin : g_lat2
      logic [W-1:0] s1_data;
      logic         s1_v;
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          s1_data  <= '0;
          s1_v     <= 1'b0;
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          s1_v     <= acc_rd[p];
          rvalid_q <= s1_v;
          if (acc_rd[p]) s1_data <= rdata;
          if (s1_v)      dout_q  <= s1_data;
        end
      end
    end else begin : g_lat1
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          dout_q   <= '0;
          rvalid_q <= 1'b0;
        end else begin
          rvalid_q <= acc_rd[p];
          if (acc_rd[p]) dout_q <= rdata;
        end
      end
    end
  end

  assign dout_a   = g_port[0].dout_q;
  assign rvalid_a = g_port[0].rvalid_q;
  assign dout_b   = g_port[1].dout_q;
  assign rvalid_b = g_port[1].rvalid_q;

`ifdef DPRAM_COLL_DET_EN
  logic hit;
  always_comb begin
    hit = 1'b0;
    for (int k = 0; k < LANES; k++) begin
      for (int j = 0; j < LANES; j++) begin
        if (be[0][k] && be[1][j] && (idx[0][k] == idx[1][j])) hit = 1'b1;
      end
    end
    hit = hit & acc_wr[0] & acc_wr[1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) coll <= 1'b0;
    else        coll <= hit;
  end
`else
  assign coll = 1'b0;
`endif

endmodule

// File: doc/dpram_wide_be.md
Name: dpram_wide_be

Overview:
- Parametrised successor to the team's byte-addressed dual-port feature-map RAM.
- Each port accesses LANES consecutive bytes starting at any byte address. Addressing wraps modulo ADDR_LINE.
- Adds per-byte write enables, a request/valid read handshake, selectable read latency, a hardware memory-clear engine (replacing the unsynthesisable reset loop) and a cross-port write-collision flag.
- Sits between the DMA/line loader and the systolic-array feeders.

Parameters:
- ADDR_WIDTH, 19: byte address width.
- ADDR_LINE, 519168: memory depth in bytes (416x416x3). Must be ≤ 2**ADDR_WIDTH and ≥ LANES.
- DATA_WIDTH, 8: bits per byte lane.
- LANES, 16: bytes per port access. Port data width W = LANES*DATA_WIDTH.
- RD_LAT, 1: read latency in cycles. Legal values 1 or 2; 2 adds an output register stage.

Ports:
- clk  in  1  clock
- rst_n  in  1  asynchronous active-low reset
- clr  in  1  one-cycle pulse; starts a memory clear
- init_busy  out  1  high while the clear engine runs
- en_a  in  1  port A request
- we_a  in  1  port A write (when en_a=1); 0 = read
- be_a  in  LANES  port A byte enables; bit k controls byte addr_a+k
- addr_a  in  ADDR_WIDTH  port A start byte address
- din_a  in  W  port A write data; byte k = din_a[k*DATA_WIDTH +: DATA_WIDTH]
- dout_a  out  W  port A read data
- rvalid_a  out  1  port A read data valid, one-cycle pulse
- en_b, we_b, be_b, addr_b, din_b, dout_b, rvalid_b: same as port A, for port B
- coll  out  1  cross-port write-collision flag, one-cycle pulse

Behaviour:
- Reset (rst_n low, asynchronous):
  - dout_a/dout_b=0, rvalid_a/rvalid_b=0, coll=0.
  - Clear engine enters CLEAR, so init_busy=1 from the first cycle after reset release.
  - Memory contents are not reset directly.
- Clear engine FSM, states IDLE and CLEAR:
  - CLEAR: writes zero to LANES bytes per cycle at pointer p. p starts at 0 and advances by LANES.
  - Final word is partial when ADDR_LINE mod LANES ≠ 0; bytes ≥ ADDR_LINE are not written.
  - CLEAR→IDLE after the word containing byte ADDR_LINE-1; init_busy drops the next cycle.
  - Sweep length is ceil(ADDR_LINE/LANES) cycles (32448 at defaults).
  - IDLE→CLEAR on clr=1.
  - clr during CLEAR restarts the sweep at p=0.
  - While init_busy=1, en_a and en_b are ignored: no writes and no rvalid.
  - Reads in flight when clr arrives still complete.
- Addressing: byte k of an access is at (addr+k) mod ADDR_LINE. An addr ≥ ADDR_LINE is first reduced mod ADDR_LINE.
- Write (en & we): byte k is written at the clock edge iff be[k]=1. No rvalid; dout holds its previous value.
- Read (en & ~we):
  - Data is sampled at the request edge, read-first: a same-cycle write from the other port to the same byte is not visible.
  - RD_LAT=1: dout and rvalid update on the edge after the request.
  - RD_LAT=2: one cycle later.
  - be is ignored on reads.
  - A request every cycle is legal; throughput is 1 per port per cycle, fully pipelined.
  - dout holds its value when rvalid=0.
- Simultaneous writes from both ports to the same byte (both be bits set): port A's data wins.
- Byte ranges of the two ports may overlap partially, including across the wrap boundary. Non-overlapping bytes are written by their own port.

Optional Feature:
- Macro DPRAM_COLL_DET_EN.
- Defined: coll pulses 1 on the edge after any cycle in which both ports write, with enabled bytes, to at least one common physical byte (wrap included).
- Undefined: coll is tied to 0 and no comparison logic is built. All other behaviour is identical.

Decomposition:
- Package dpram_pkg holds:
  - clear-state enum (IDLE, CLEAR);
  - function computing the wrapped byte index;
  - localparams W and CLR_WORDS = ceil(ADDR_LINE/LANES);
  - RD_LAT legality check.
- One natural sub-module: dpram_clear_fsm, which owns state, pointer and init_busy and drives the zero-write port.
- Core memory and read pipeline stay in dpram_wide_be.

Test Plan (ADDR_LINE=64, LANES=4, DATA_WIDTH=8 unless stated):
1. Reset, then wait → init_busy=1 for 16 cycles, then 0. Read addr 0..60 → all 0. Set ADDR_LINE=62: sweep takes 16 cycles and the last word writes 2 bytes.
2. Port A writes addr=10, din=0x44332211, be=0b0101 onto pre-written 0xDDCCBBAA → read → 0xDDCCBB11 wait… bytes 10,12 written: result 0xDD33BB11, with rvalid one cycle after the request (RD_LAT=1) or two cycles after (RD_LAT=2).
3. Write addr=62, din=0x04030201, be=0xF → bytes 62,63,0,1 = 01,02,03,04. Read addr=126 (126 mod 64 = 62) → 0x04030201.
4. Same cycle: A writes addr=20 with 0xAAAAAAAA, B writes addr=22 with 0xBBBBBBBB, both be=0xF → bytes 20..21=AA, 22..23=AA (A wins), 24..25=BB; coll=1 for one cycle with the macro, 0 without it.
5. B reads addr=30 while A writes 0x55 to byte 30 in the same cycle → B returns old byte 30. A read the next cycle returns 0x55.
6. clr mid-operation, with back-to-back reads outstanding → in-flight rvalid still pulses. Requests are ignored while init_busy=1. Memory reads 0 after the sweep completes.
